// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle ops, shift-add MUL, restoring DIVU/REMU.
// Ports: clk, rst_n (async low), in_valid/in_ready + op/a/b request,
//        out_valid/out_ready + result/zero/err response.
// Build option: define SEQ_ALU_DIV_EN to include the DIVU/REMU datapath;
//               otherwise opcodes 01000/01001 are reported as illegal.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00011;
    localparam logic [4:0] OP_OR   = 5'b00100;
    localparam logic [4:0] OP_SLT  = 5'b00101;
    localparam logic [4:0] OP_BEQ  = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b00111;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [4:0] OP_DIVU = 5'b01000;
    localparam logic [4:0] OP_REMU = 5'b01001;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    // Shared iterative registers.
    // MUL: acc=partial product, x=multiplicand, y=multiplier.
    // DIV: acc=remainder, x=dividend shifting into quotient, y=divisor.
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] acc_n, x_n, y_n;
    logic [WIDTH-1:0] s_res, it_res;
    logic             s_err, it_err;
    logic             is_iter, last;
    logic [WIDTH-1:0] mul_acc;

`ifdef SEQ_ALU_DIV_EN
    logic [4:0]       op_q;
    logic [WIDTH:0]   minu;
    logic             ge;
    logic [WIDTH-1:0] diff;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = is_iter ? BUSY : DONE;
            BUSY: if (last)     state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ---------------- Decode ----------------
`ifdef SEQ_ALU_DIV_EN
    assign is_iter = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
    assign is_iter = (op == OP_MUL);
`endif
    assign last = (cnt == CW'(WIDTH - 1));

    // ---------------- Single-cycle ALU ----------------
    always_comb begin
        s_res = '0;
        s_err = 1'b0;
        case (op)
            OP_ADD: s_res = a + b;
            OP_SUB: s_res = a - b;
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_SLT: s_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_BEQ: s_res = a - b;
            default: s_err = 1'b1;
        endcase
    end

    // ---------------- Iteration step ----------------
    assign mul_acc = acc + (y[0] ? x : '0);

`ifdef SEQ_ALU_DIV_EN
    // Trial subtract of divisor from {remainder, next dividend bit}.
    // Divisor 0 always "fits", giving all-ones quotient and remainder = a.
    assign minu = {acc, x[WIDTH-1]};
    assign ge   = (minu >= {1'b0, y});
    assign diff = minu[WIDTH-1:0] - y;
`endif

    always_comb begin
        acc_n  = mul_acc;
        x_n    = x << 1;
        y_n    = y >> 1;
        it_res = acc_n;
        it_err = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        if (op_q != OP_MUL) begin
            acc_n  = ge ? diff : minu[WIDTH-1:0];
            x_n    = {x[WIDTH-2:0], ge};
            y_n    = y;
            it_res = (op_q == OP_REMU) ? acc_n : x_n;
            it_err = (y == '0);
        end
`endif
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            x      <= '0;
            y      <= '0;
            result <= '0;
            zero   <= 1'b0;
            err    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            op_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_iter) begin
                            cnt <= '0;
                            acc <= '0;
                            x   <= a;
                            y   <= b;
`ifdef SEQ_ALU_DIV_EN
                            op_q <= op;
`endif
                        end else begin
                            result <= s_res;
                            zero   <= (s_res == '0);
                            err    <= s_err;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_n;
                    x   <= x_n;
                    y   <= y_n;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result <= it_res;
                        zero   <= (it_res == '0);
                        err    <= it_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checks of seq_alu against
// an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [4:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, err;
    logic [W-1:0] result;

    int nvec = 0;
    int nerr = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [4:0] o, input logic [W-1:0] p,
                         input logic [W-1:0] q, output logic [W-1:0] r,
                         output logic e, output int lat);
        logic [2*W-1:0] prod;
        r = '0;
        e = 1'b0;
        lat = 1;
        case (o)
            5'd1: r = p + q;
            5'd2: r = p - q;
            5'd3: r = p & q;
            5'd4: r = p | q;
            5'd5: r = ($signed(p) < $signed(q)) ? W'(1) : W'(0);
            5'd6: r = p - q;
            5'd7: begin
                prod = {{W{1'b0}}, p} * {{W{1'b0}}, q};
                r = prod[W-1:0];
                lat = W + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            5'd8: begin
                r = (q == 0) ? {W{1'b1}} : p / q;
                e = (q == 0);
                lat = W + 1;
            end
            5'd9: begin
                r = (q == 0) ? p : p % q;
                e = (q == 0);
                lat = W + 1;
            end
`endif
            default: e = 1'b1;
        endcase
    endtask

    // Issue one request from IDLE and collect the response.
    task automatic run_op(input logic [4:0] o, input logic [W-1:0] p,
                          input logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output logic e,
                          output int lat, output int rdy_seen);
        @(negedge clk);
        op = o; a = p; b = q; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        rdy_seen = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        r = result; z = zero; e = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 ||
            zero !== 1'b0 || err !== 1'b0) begin
            nerr++;
            $display("FAIL reset rdy=%b vld=%b res=%h z=%b e=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, zero, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [4:0]   ops [15] = '{1, 2, 3, 4, 5, 5, 6, 7, 7, 8, 9, 8, 9, 0, 31};
        logic [W-1:0] as  [15] = '{10, 30, 'hAA, 'hAA, 'hFFFFFFFF, 1, 100,
                                   7, 'hFFFFFFFF, 100, 100, 5, 5, 3, 9};
        logic [W-1:0] bs  [15] = '{20, 15, 'hCC, 'hCC, 1, 'hFFFFFFFF, 100,
                                   6, 2, 7, 7, 0, 0, 4, 9};
        logic [W-1:0] r, er;
        logic z, e, ee;
        int lat, el, rs;
        for (int i = 0; i < 15; i++) begin
            run_op(ops[i], as[i], bs[i], r, z, e, lat, rs);
            model(ops[i], as[i], bs[i], er, ee, el);
            nvec++;
            if (r !== er || z !== (er == 0) || e !== ee) begin
                nerr++;
                $display("FAIL dir_res op=%0d res=%h z=%b e=%b want %h %b %b",
                         ops[i], r, z, e, er, (er == 0), ee);
            end
            nvec++;
            if (lat != el || rs != 0) begin
                nerr++;
                $display("FAIL dir_lat op=%0d lat=%0d rdy=%0d want %0d 0",
                         ops[i], lat, rs, el);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]   o;
        logic [W-1:0] p, q, r, er;
        logic z, e, ee;
        int lat, el, rs, k;
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 11);
            o = (k <= 9) ? 5'(k) : 5'($urandom_range(10, 31));
            p = $urandom;
            k = $urandom_range(0, 7);
            q = (k == 0) ? '0 : (k < 3) ? W'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) p = W'($urandom_range(0, 300));
            run_op(o, p, q, r, z, e, lat, rs);
            model(o, p, q, er, ee, el);
            nvec++;
            if (r !== er || z !== (er == 0) || e !== ee) begin
                nerr++;
                $display("FAIL rnd_res op=%0d a=%h b=%h res=%h z=%b e=%b want %h %b %b",
                         o, p, q, r, z, e, er, (er == 0), ee);
            end
            nvec++;
            if (lat != el || rs != 0) begin
                nerr++;
                $display("FAIL rnd_lat op=%0d lat=%0d rdy=%0d want %0d 0",
                         o, lat, rs, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nr, nv, bad;
        nr = 0; nv = 0; bad = 0;
        @(negedge clk);
        op = 5'd1; a = 123; b = 456; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (in_ready) nr++;
            if (out_valid) begin
                nv++;
                if (result !== W'(579)) bad++;
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        nvec++;
        if (nr != 5 || nv != 5 || bad != 0) begin
            nerr++;
            $display("FAIL b2b rdy=%0d vld=%0d bad=%0d want 5 5 0", nr, nv, bad);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        op = 5'd1; a = 3; b = 4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        op = 5'd2; a = 50; b = 8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nvec++;
            if (out_valid !== 1'b1 || result !== W'(7) || in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL hold cyc=%0d vld=%b res=%h rdy=%b want 1 7 0",
                         i, out_valid, result, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL release rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || result !== W'(42) || err !== 1'b0) begin
            nerr++;
            $display("FAIL second vld=%b res=%h e=%b want 1 2a 0",
                     out_valid, result, err);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r;
        logic z, e;
        int lat, rs;
        @(negedge clk);
        op = 5'd7; a = 7; b = 6; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid vld=%b res=%h rdy=%b want 0 0 1",
                     out_valid, result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(5'd1, 5, 9, r, z, e, lat, rs);
        nvec++;
        if (r !== W'(14) || z !== 1'b0 || e !== 1'b0 || lat != 1) begin
            nerr++;
            $display("FAIL post_rst_add res=%h z=%b e=%b lat=%0d want e 0 0 1",
                     r, z, e, lat);
        end
        run_op(5'd31, 77, 88, r, z, e, lat, rs);
        nvec++;
        if (r !== '0 || z !== 1'b1 || e !== 1'b1 || lat != 1) begin
            nerr++;
            $display("FAIL post_rst_ill res=%h z=%b e=%b lat=%0d want 0 1 1 1",
                     r, z, e, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
